// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes, 8-bit CPU address.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             READ,
  input  logic             WRITE,
  input  logic [7:0]       ADDRESS,
  input  logic [7:0]       WRITEDATA,
  output logic [7:0]       READDATA,
  output logic             BUSYWAIT,
  output logic             MEM_READ,
  output logic             MEM_WRITE,
  output logic [5:0]       MEM_ADDRESS,
  output logic [31:0]      MEM_WRITEDATA,
  input  logic [31:0]      MEM_READDATA,
  input  logic             MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [CNT_W-1:0] HIT_COUNT,
  output logic [CNT_W-1:0] MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  // Handshake: the CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while BUSYWAIT=1;
  // memory requests stay asserted until the controller observes MEM_BUSYWAIT=0
  // at a posedge no earlier than the second one spent in WRITEBACK/FETCH.
  state_t state, state_next;

  logic [7:0]  valid_bits;
  logic [7:0]  dirty_bits;
  logic [2:0]  tag_mem  [8];
  logic [31:0] data_mem [8];

  logic        first_cycle;
  logic [7:0]  readdata_q;

  logic [2:0]  addr_tag;
  logic [2:0]  addr_index;
  logic [1:0]  addr_offset;
  logic [31:0] line_data;
  logic [7:0]  line_byte;
  logic        request;
  logic        hit;
  logic        read_hit;
  logic        write_hit;
  logic        exit_ok;

  assign addr_tag    = ADDRESS[7:5];
  assign addr_index  = ADDRESS[4:2];
  assign addr_offset = ADDRESS[1:0];

  assign request   = READ | WRITE;
  assign hit       = valid_bits[addr_index] && (tag_mem[addr_index] == addr_tag);
  assign read_hit  = (state == S_IDLE) && READ && !WRITE && hit;
  assign write_hit = (state == S_IDLE) && WRITE && hit;
  assign exit_ok   = !first_cycle && !MEM_BUSYWAIT;

  always_comb begin
    line_data = data_mem[addr_index];
    line_byte = line_data[{addr_offset, 3'b000} +: 8];
  end

  // Next state and memory-side outputs
  always_comb begin
    state_next    = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    case (state)
      S_IDLE: begin
        if (request && !hit) begin
          if (valid_bits[addr_index] && dirty_bits[addr_index]) begin
            state_next = S_WRITEBACK;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_mem[addr_index], addr_index};
        MEM_WRITEDATA = line_data;
        if (exit_ok) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_index};
        if (exit_ok) begin
          state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Reset gates the stall so a CPU still presenting a request is released at once.
  assign BUSYWAIT = !RESET && ((state != S_IDLE) || (request && !hit));
  assign READDATA = read_hit ? line_byte : readdata_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      first_cycle <= 1'b0;
    end else begin
      state       <= state_next;
      first_cycle <= (state_next != state);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      readdata_q <= 8'd0;
    end else if (read_hit) begin
      readdata_q <= line_byte;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_bits <= 8'd0;
      dirty_bits <= 8'd0;
    end else if (state == S_UPDATE) begin
      valid_bits[addr_index] <= 1'b1;
      dirty_bits[addr_index] <= 1'b0;
    end else if (write_hit) begin
      dirty_bits[addr_index] <= 1'b1;
    end
  end

  // Line payload and tags carry no reset; valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (state == S_UPDATE) begin
      data_mem[addr_index] <= MEM_READDATA;
      tag_mem[addr_index]  <= addr_tag;
    end else if (write_hit) begin
      data_mem[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  // A hit following a refill belongs to the access that missed, so it is not counted.
  logic miss_pending;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HIT_COUNT    <= '0;
      MISS_COUNT   <= '0;
      miss_pending <= 1'b0;
    end else if ((state == S_IDLE) && request) begin
      if (hit) begin
        miss_pending <= 1'b0;
        if (!miss_pending && (HIT_COUNT != '1)) begin
          HIT_COUNT <= HIT_COUNT + CNT_W'(1);
        end
      end else begin
        miss_pending <= 1'b1;
        if (MISS_COUNT != '1) begin
          MISS_COUNT <= MISS_COUNT + CNT_W'(1);
        end
      end
    end
  end
`else
  // Counters need at least one bit when they are built.
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed miss/evict/reset sequences plus a hit-vector table.
module tb_dcache_controller;

  localparam int CNT_W = 16;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [CNT_W-1:0] HIT_COUNT;
  logic [CNT_W-1:0] MISS_COUNT;
`endif

  dcache_controller #(.CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model + transaction scoreboard ----------------
  // Entry layout: {is_write, block address, write data (0 for fetches)}
  logic [38:0] exp_q[$];
  logic [31:0] mem [64];
  int          mem_lat = 0;
  int          mem_cnt = 0;
  logic [1:0]  prev_kind = 2'd0;
  logic [5:0]  prev_addr = 6'd0;

  task automatic exp_push(input logic w, input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({w, a, d});
  endtask

  always @(negedge CLK) begin
    logic [1:0]  cur;
    logic [38:0] got;
    check("mem_rd_wr_exclusive", 64'(MEM_READ & MEM_WRITE), 64'd0);
    cur = MEM_WRITE ? 2'd2 : (MEM_READ ? 2'd1 : 2'd0);
    if (cur != 2'd0) begin
      if ((cur != prev_kind) || (MEM_ADDRESS != prev_addr)) begin
        mem_cnt = 0;
        got = {MEM_WRITE, MEM_ADDRESS, (MEM_WRITE ? MEM_WRITEDATA : 32'h0)};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mem_unexpected: got %0h expected none", got);
        end else begin
          check("mem_txn", 64'(got), 64'(exp_q.pop_front()));
        end
      end
      if (mem_cnt < mem_lat) begin
        MEM_BUSYWAIT = 1'b1;
        mem_cnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        if (MEM_READ)  MEM_READDATA = mem[MEM_ADDRESS];
        if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
      end
    end else begin
      MEM_BUSYWAIT = 1'b0;
      mem_cnt = 0;
    end
    prev_kind = cur;
    prev_addr = MEM_ADDRESS;
  end

  // ---------------- CPU driver ----------------
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        input int exp_stall, input string name);
    int stalls;
    @(negedge CLK);
    READ = rd;
    WRITE = wr;
    ADDRESS = addr;
    WRITEDATA = wdata;
    #1;
    stalls = 0;
    while (BUSYWAIT && (stalls < 100)) begin
      stalls++;
      @(negedge CLK);
      #1;
    end
    check({name, "_stall"}, 64'(stalls), 64'(exp_stall));
    check({name, "_readdata"}, 64'(READDATA), 64'(exp_rdata));
  endtask

  task automatic idle();
    @(negedge CLK);
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  // ---------------- test sequence ----------------
  initial begin
    logic seen;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    mem[1]  = 32'h44332211;
    mem[2]  = 32'h2B2A2928;
    mem[4]  = 32'h88776655;
    mem[9]  = 32'h0D0C0B0A;
    mem[12] = 32'h1F1E1D1C;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = 32'h0;
    READ = 1'b0;
    WRITE = 1'b0;
    ADDRESS = 8'h00;
    WRITEDATA = 8'h00;
    RESET = 1'b1;

    #12;
    check("rst_busywait", 64'(BUSYWAIT), 64'd0);
    check("rst_mem_read", 64'(MEM_READ), 64'd0);
    check("rst_mem_write", 64'(MEM_WRITE), 64'd0);
    check("rst_mem_address", 64'(MEM_ADDRESS), 64'd0);
    check("rst_mem_writedata", 64'(MEM_WRITEDATA), 64'd0);
    check("rst_readdata", 64'(READDATA), 64'd0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_count", 64'(HIT_COUNT), 64'd0);
    check("rst_miss_count", 64'(MISS_COUNT), 64'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;

    // Cold read, then two hits
    mem_lat = 2;
    exp_push(1'b0, 6'h01, 32'h0);
    access(1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 5, "cold_read");
    access(1'b1, 1'b0, 8'h07, 8'h00, 8'h44, 0, "read_hit_07");
    access(1'b1, 1'b0, 8'h06, 8'h00, 8'h33, 0, "read_hit_06");
`ifdef DCACHE_STATS_EN
    @(negedge CLK);
    READ = 1'b0;
    #1;
    check("stats_hit_count", 64'(HIT_COUNT), 64'd2);
    check("stats_miss_count", 64'(MISS_COUNT), 64'd1);
`endif

    // Write hit dirties line 1; a conflicting read writes it back then fetches
    access(1'b0, 1'b1, 8'h04, 8'hAA, 8'h33, 0, "write_hit_04");
    mem_lat = 1;
    exp_push(1'b1, 6'h01, 32'h443322AA);
    exp_push(1'b0, 6'h09, 32'h0);
    access(1'b1, 1'b0, 8'h24, 8'h00, 8'h0A, 6, "dirty_evict_24");

    // Clean evict with minimum-length FETCH; refetched block carries the written-back byte
    mem_lat = 0;
    exp_push(1'b0, 6'h01, 32'h0);
    access(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 4, "clean_evict_04");

    // Write miss on an invalid line: fetch, then commit the byte and mark dirty
    mem_lat = 3;
    exp_push(1'b0, 6'h04, 32'h0);
    access(1'b0, 1'b1, 8'h13, 8'h5C, 8'hAA, 6, "write_miss_13");
    access(1'b1, 1'b0, 8'h13, 8'h00, 8'h5C, 0, "read_back_13");
    mem_lat = 0;
    exp_push(1'b1, 6'h04, 32'h5C776655);
    exp_push(1'b0, 6'h0C, 32'h0);
    access(1'b1, 1'b0, 8'h33, 8'h00, 8'h1F, 6, "dirty_evict_33");

    // Hit table over resident lines 1 (0x443322AA) and 4 (0x1F1E1D1C)
    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 8'h05, wdata: 8'h00, exp_rdata: 8'h22};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 8'h06, wdata: 8'h77, exp_rdata: 8'h22};
    vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 8'h06, wdata: 8'h00, exp_rdata: 8'h77};
    vecs[3] = '{rd: 1'b1, wr: 1'b1, addr: 8'h30, wdata: 8'h99, exp_rdata: 8'h77};
    vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 8'h30, wdata: 8'h00, exp_rdata: 8'h99};
    vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 8'h31, wdata: 8'h00, exp_rdata: 8'h1D};
    vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 8'h07, wdata: 8'h00, exp_rdata: 8'h44};
    vecs[7] = '{rd: 1'b0, wr: 1'b1, addr: 8'h07, wdata: 8'h01, exp_rdata: 8'h44};
    vecs[8] = '{rd: 1'b1, wr: 1'b0, addr: 8'h07, wdata: 8'h00, exp_rdata: 8'h01};
    vecs[9] = '{rd: 1'b1, wr: 1'b0, addr: 8'h04, wdata: 8'h00, exp_rdata: 8'hAA};
    for (int i = 0; i < 10; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
             0, $sformatf("hit_vec%0d", i));
    end

    // Evicting line 1 must write back every byte changed by the table
    exp_push(1'b1, 6'h01, 32'h017722AA);
    exp_push(1'b0, 6'h09, 32'h0);
    access(1'b1, 1'b0, 8'h25, 8'h00, 8'h0B, 6, "dirty_evict_25");
    idle();

    // Reset during FETCH abandons the transaction
    mem_lat = 5;
    exp_push(1'b0, 6'h02, 32'h0);
    @(negedge CLK);
    READ = 1'b1;
    ADDRESS = 8'h08;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #1;
      if (MEM_READ) begin
        seen = 1'b1;
        break;
      end
    end
    check("midfetch_mem_read_seen", 64'(seen), 64'd1);
    #1;
    RESET = 1'b1;
    #1;
    check("midfetch_mem_read_drop", 64'(MEM_READ), 64'd0);
    check("midfetch_busywait_drop", 64'(BUSYWAIT), 64'd0);
    check("midfetch_mem_write", 64'(MEM_WRITE), 64'd0);
    check("midfetch_mem_address", 64'(MEM_ADDRESS), 64'd0);
    @(negedge CLK);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("post_reset_readdata", 64'(READDATA), 64'd0);
`ifdef DCACHE_STATS_EN
    check("post_reset_hit_count", 64'(HIT_COUNT), 64'd0);
    check("post_reset_miss_count", 64'(MISS_COUNT), 64'd0);
`endif
    mem_lat = 0;
    exp_push(1'b0, 6'h02, 32'h0);
    access(1'b1, 1'b0, 8'h08, 8'h00, 8'h28, 4, "refetch_08");
    exp_push(1'b0, 6'h01, 32'h0);
    access(1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 4, "refetch_05");
    idle();
    repeat (2) @(negedge CLK);

    check("mem_txn_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
